// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t   : FSM states (IDLE, RUN, DONE), also exported for debug
//   MODE_ADD  : mode value selecting a + b + cin
//   MODE_SUB  : mode value selecting a - b
//   cnt_width : bit-counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Counter must index bits 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operation request / result bundle for serial_adder.
//   master : drives start, mode, a, b, cin; observes busy, done, sum, cout, overflow
//   slave  : the adder itself
//
// Handshake: start is a request that is honoured only while the adder is
// idle (busy=0 and done=0). An accepted start latches a, b, mode and cin on
// that clock edge; busy rises the next cycle and stays high while bits are
// processed. done is a one-cycle pulse in which busy is low and sum, cout and
// overflow have just been updated; those results hold until the next done.
// A start presented while busy or during the done cycle is dropped.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder used as the serial datapath cell.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands are latched on an accepted start and
// processed LSB-first, one bit per clock, through a single full-adder cell.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : serial_adder_if slave (start/mode/a/b/cin in,
//               busy/done/sum/cout/overflow out, all outputs registered)
//   dbg_state : current FSM state
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output state_t         dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Holds the WIDTH-1 bits already produced; the final bit comes straight
  // from the cell, so the full result is {fa_s, res}.
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_full;
  logic             last_bit;

  serial_fa_cell u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign res_full = {fa_s, res};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a   <= bus.a;
            // Subtract is a + ~b + 1: invert b and seed the carry with 1.
            op_b   <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
            carry  <= (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          res   <= res_full[WIDTH-1:1];
          carry <= fa_co;
          if (last_bit) begin
            // carry still holds the carry into the MSB here, so the signed
            // overflow is that value XOR the final carry out.
            sum_q  <= res_full;
            cout_q <= fa_co;
            ovf_q  <= carry ^ fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state;

endmodule
